// File: rtl/rate_lock_controller.sv
// Rate lock controller: acquires a stable rate from measured samples, tracks it
// while locked, and derives the high/low half rates for the recovery datapath.
module rate_lock_controller #(
    parameter int RATE_W  = 16,
    parameter int LOCK_W  = 4,
    parameter int TIMER_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [2:0]         cfg_mode,
    input  logic [1:0]         cfg_polarity,
    input  logic               cfg_odd_high,
    input  logic [RATE_W-1:0]  cfg_tolerance,
    input  logic [RATE_W-1:0]  cfg_min_rate,
    input  logic [LOCK_W-1:0]  cfg_lock_target,
    input  logic [LOCK_W-1:0]  cfg_violation_limit,
    input  logic [TIMER_W-1:0] cfg_pause_timeout,
    input  logic               sample_valid,
    input  logic [RATE_W-1:0]  sample_rate,
    output logic [1:0]         edge_sel,
    output logic               locked,
    output logic               paused,
    output logic               rate_update,
    output logic               violation,
    output logic [RATE_W-1:0]  locked_rate,
    output logic [RATE_W-1:0]  half_rate_high,
    output logic [RATE_W-1:0]  half_rate_low,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACQUIRE = 3'd1,
        S_LOCKED  = 3'd2,
        S_PAUSED  = 3'd3
    } state_t;

    localparam logic [LOCK_W-1:0]  LOCK_ONE  = LOCK_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    // |a - b| <= tol, evaluated one bit wider so the difference never wraps
    function automatic logic within_tol(input logic [RATE_W-1:0] a,
                                        input logic [RATE_W-1:0] b,
                                        input logic [RATE_W-1:0] tol);
        logic [RATE_W:0] diff;
        if (a >= b) diff = {1'b0, a} - {1'b0, b};
        else        diff = {1'b0, b} - {1'b0, a};
        return diff <= {1'b0, tol};
    endfunction

    // Returns {high, low}; split modes give the odd remainder to one half
    function automatic logic [2*RATE_W-1:0] split_rate(input logic [RATE_W-1:0] rate,
                                                       input logic single,
                                                       input logic odd_high);
        logic [RATE_W-1:0] base;
        base = rate >> 1;
        if (single)             return {rate, rate};
        else if (!rate[0])      return {base, base};
        else if (odd_high)      return {base + RATE_W'(1), base};
        else                    return {base, base + RATE_W'(1)};
    endfunction

    state_t              state_r, state_s;
    logic [2:0]          mode_r, mode_s;
    logic [1:0]          pol_r, pol_s;
    logic [RATE_W-1:0]   cand_r, cand_s;
    logic [LOCK_W-1:0]   match_cnt_r, match_cnt_s, viol_cnt_r, viol_cnt_s;
    logic [TIMER_W-1:0]  timer_r, timer_s;
    logic                locked_r, locked_s, paused_r, paused_s;
    logic                rate_update_r, rate_update_s, violation_r, violation_s;
    logic [RATE_W-1:0]   locked_rate_r, locked_rate_s, half_hi_r, half_hi_s, half_lo_r, half_lo_s;
    logic [LOCK_W-1:0]   lock_target_s, viol_limit_s;
    logic [RATE_W-1:0]   ref_s;
    logic                match_s, pause_mode_s;

    assign lock_target_s = (cfg_lock_target == '0) ? LOCK_ONE : cfg_lock_target;
    assign viol_limit_s  = (cfg_violation_limit == '0) ? LOCK_ONE : cfg_violation_limit;
    assign ref_s         = (state_r == S_ACQUIRE) ? cand_r : locked_rate_r;
    assign match_s       = within_tol(sample_rate, ref_s, cfg_tolerance);
    assign pause_mode_s  = mode_r[0];
    assign edge_sel      = (mode_r[2] || pol_r == 2'd0) ? 2'b11 :
                           (pol_r == 2'd1) ? 2'b01 : 2'b10;

    // Next-state, counter and output computation
    always_comb begin
        state_s       = state_r;
        mode_s        = mode_r;
        pol_s         = pol_r;
        cand_s        = cand_r;
        match_cnt_s   = match_cnt_r;
        viol_cnt_s    = viol_cnt_r;
        timer_s       = timer_r;
        locked_s      = locked_r;
        paused_s      = paused_r;
        locked_rate_s = locked_rate_r;
        rate_update_s = 1'b0;
        violation_s   = 1'b0;
        if (!enable) begin
            state_s     = S_IDLE;
            cand_s      = '0;
            match_cnt_s = '0;
            viol_cnt_s  = '0;
            timer_s     = '0;
            locked_s    = 1'b0;
            paused_s    = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_s = S_ACQUIRE;
                    mode_s  = (cfg_mode > 3'd5) ? 3'd0 : cfg_mode;
                    pol_s   = (cfg_polarity == 2'd3) ? 2'd0 : cfg_polarity;
                end
                S_ACQUIRE: begin
                    if (sample_valid) begin
                        if (match_cnt_r != '0 && match_s) begin
                            match_cnt_s = match_cnt_r + LOCK_ONE;
                        end else begin
                            cand_s      = sample_rate;
                            match_cnt_s = LOCK_ONE;
                        end
                        if (match_cnt_s >= lock_target_s) begin
                            state_s       = S_LOCKED;
                            locked_s      = 1'b1;
                            locked_rate_s = cand_s;
                            rate_update_s = 1'b1;
                            viol_cnt_s    = '0;
                            timer_s       = '0;
                        end else begin
                            state_s = S_ACQUIRE;
                        end
                    end else begin
                        state_s = S_ACQUIRE;
                    end
                end
                S_LOCKED, S_PAUSED: begin
                    if (!pause_mode_s)            timer_s = '0;
                    else if (sample_valid)        timer_s = '0;
                    else if (timer_r != '1)       timer_s = timer_r + TIMER_ONE;
                    else                          timer_s = timer_r;
                    if (sample_valid) begin
                        if (match_s) begin
                            viol_cnt_s = '0;
                            state_s    = S_LOCKED;
                            paused_s   = 1'b0;
                        end else if (pause_mode_s && sample_rate < (locked_rate_r >> 1)
                                     && sample_rate >= cfg_min_rate) begin
                            locked_rate_s = sample_rate;
                            rate_update_s = 1'b1;
                            viol_cnt_s    = '0;
                            state_s       = S_LOCKED;
                            paused_s      = 1'b0;
                        end else if (pause_mode_s && ({1'b0, sample_rate} >
                                     ({1'b0, locked_rate_r} + {1'b0, cfg_tolerance}))) begin
                            state_s = state_r;   // long gap between bursts, not an error
                        end else begin
                            violation_s = 1'b1;
                            viol_cnt_s  = viol_cnt_r + LOCK_ONE;
                            if (viol_cnt_s >= viol_limit_s) begin
                                state_s     = S_ACQUIRE;
                                locked_s    = 1'b0;
                                paused_s    = 1'b0;
                                match_cnt_s = '0;
                                viol_cnt_s  = '0;
                                timer_s     = '0;
                            end else begin
                                state_s = state_r;
                            end
                        end
                    end else if (pause_mode_s && state_r == S_LOCKED
                                 && timer_s >= cfg_pause_timeout) begin
                        state_s  = S_PAUSED;
                        paused_s = 1'b1;
                    end else begin
                        state_s = state_r;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
        {half_hi_s, half_lo_s} = split_rate(locked_rate_s, (mode_s <= 3'd1), cfg_odd_high);
    end

    // State and registered outputs, asynchronously cleared by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            mode_r        <= 3'd0;
            pol_r         <= 2'd0;
            cand_r        <= '0;
            match_cnt_r   <= '0;
            viol_cnt_r    <= '0;
            timer_r       <= '0;
            locked_r      <= 1'b0;
            paused_r      <= 1'b0;
            rate_update_r <= 1'b0;
            violation_r   <= 1'b0;
            locked_rate_r <= '0;
            half_hi_r     <= '0;
            half_lo_r     <= '0;
        end else begin
            state_r       <= state_s;
            mode_r        <= mode_s;
            pol_r         <= pol_s;
            cand_r        <= cand_s;
            match_cnt_r   <= match_cnt_s;
            viol_cnt_r    <= viol_cnt_s;
            timer_r       <= timer_s;
            locked_r      <= locked_s;
            paused_r      <= paused_s;
            rate_update_r <= rate_update_s;
            violation_r   <= violation_s;
            locked_rate_r <= locked_rate_s;
            half_hi_r     <= half_hi_s;
            half_lo_r     <= half_lo_s;
        end
    end

    assign state          = state_r;
    assign locked         = locked_r;
    assign paused         = paused_r;
    assign rate_update    = rate_update_r;
    assign violation      = violation_r;
    assign locked_rate    = locked_rate_r;
    assign half_rate_high = half_hi_r;
    assign half_rate_low  = half_lo_r;

endmodule

// File: tb/tb_rate_lock_controller.sv
// Directed testbench for rate_lock_controller: inputs change on the falling
// edge, outputs are checked on the following falling edge.
module tb_rate_lock_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  cfg_mode = 3'd0;
    logic [1:0]  cfg_polarity = 2'd0;
    logic        cfg_odd_high = 1'b1;
    logic [15:0] cfg_tolerance = 16'd2;
    logic [15:0] cfg_min_rate = 16'd20;
    logic [3:0]  cfg_lock_target = 4'd3;
    logic [3:0]  cfg_violation_limit = 4'd2;
    logic [19:0] cfg_pause_timeout = 20'd1000;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_rate = 16'd0;
    logic [1:0]  edge_sel;
    logic        locked, paused, rate_update, violation;
    logic [15:0] locked_rate, half_rate_high, half_rate_low;
    logic [2:0]  state;

    int passed = 0;
    int total = 0;
    int ru_seen = 0;
    int ru_base = 0;

    rate_lock_controller dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_mode(cfg_mode),
        .cfg_polarity(cfg_polarity), .cfg_odd_high(cfg_odd_high),
        .cfg_tolerance(cfg_tolerance), .cfg_min_rate(cfg_min_rate),
        .cfg_lock_target(cfg_lock_target), .cfg_violation_limit(cfg_violation_limit),
        .cfg_pause_timeout(cfg_pause_timeout), .sample_valid(sample_valid),
        .sample_rate(sample_rate), .edge_sel(edge_sel), .locked(locked),
        .paused(paused), .rate_update(rate_update), .violation(violation),
        .locked_rate(locked_rate), .half_rate_high(half_rate_high),
        .half_rate_low(half_rate_low), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rate_update === 1'b1) ru_seen++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] r);
        sample_valid = 1'b1;
        sample_rate  = r;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic restart(input logic [2:0] m, input logic [1:0] p);
        enable = 1'b0;
        tick(1);
        cfg_mode     = m;
        cfg_polarity = p;
        enable       = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        #1;
        total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else passed++;
        total++; if ({locked, paused, rate_update, violation} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {locked, paused, rate_update, violation}); else passed++;
        total++; if ({locked_rate, half_rate_high, half_rate_low} !== 48'd0)
            $display("FAIL reset_rates: got %0d/%0d/%0d want 0/0/0", locked_rate, half_rate_high, half_rate_low); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_lock;
        restart(3'd0, 2'd1);
        total++; if (state !== 3'd1) $display("FAIL acq_state: got %0d want 1", state); else passed++;
        total++; if (edge_sel !== 2'b01) $display("FAIL edge_pos: got %b want 01", edge_sel); else passed++;
        ru_base = ru_seen;
        send(16'd100);
        send(16'd101);
        total++; if (locked !== 1'b0) $display("FAIL lock_early: got %0d want 0", locked); else passed++;
        send(16'd99);
        total++; if (locked !== 1'b1 || state !== 3'd2)
            $display("FAIL lock_now: got locked=%0d state=%0d want 1/2", locked, state); else passed++;
        total++; if (locked_rate !== 16'd100) $display("FAIL lock_rate: got %0d want 100", locked_rate); else passed++;
        total++; if (rate_update !== 1'b1) $display("FAIL lock_update: got %0d want 1", rate_update); else passed++;
        total++; if (half_rate_high !== 16'd100 || half_rate_low !== 16'd100)
            $display("FAIL single_half: got %0d/%0d want 100/100", half_rate_high, half_rate_low); else passed++;
        tick(2);
        total++; if (ru_seen - ru_base !== 1) $display("FAIL update_count: got %0d want 1", ru_seen - ru_base); else passed++;
    endtask

    task automatic test_half_rates;
        restart(3'd2, 2'd2);
        send(16'd101); send(16'd101); send(16'd101);
        total++; if (edge_sel !== 2'b10) $display("FAIL edge_neg: got %b want 10", edge_sel); else passed++;
        total++; if (half_rate_high !== 16'd51 || half_rate_low !== 16'd50)
            $display("FAIL half_odd_high: got %0d/%0d want 51/50", half_rate_high, half_rate_low); else passed++;
        cfg_odd_high = 1'b0;
        tick(1);
        total++; if (half_rate_high !== 16'd50 || half_rate_low !== 16'd51)
            $display("FAIL half_odd_low: got %0d/%0d want 50/51", half_rate_high, half_rate_low); else passed++;
        cfg_odd_high = 1'b1;
    endtask

    task automatic test_violation;
        restart(3'd0, 2'd0);
        send(16'd100); send(16'd100); send(16'd100);
        send(16'd110);
        total++; if (violation !== 1'b1 || state !== 3'd2 || locked !== 1'b1)
            $display("FAIL viol_first: got v=%0d s=%0d l=%0d want 1/2/1", violation, state, locked); else passed++;
        send(16'd90);
        total++; if (violation !== 1'b1 || state !== 3'd1 || locked !== 1'b0)
            $display("FAIL viol_unlock: got v=%0d s=%0d l=%0d want 1/1/0", violation, state, locked); else passed++;
        tick(1);
        total++; if (violation !== 1'b0) $display("FAIL viol_pulse: got %0d want 0", violation); else passed++;
    endtask

    task automatic test_pause_relock;
        restart(3'd3, 2'd1);
        send(16'd100); send(16'd100); send(16'd100);
        send(16'd40);
        total++; if (locked_rate !== 16'd40 || rate_update !== 1'b1 || violation !== 1'b0)
            $display("FAIL relock: got r=%0d u=%0d v=%0d want 40/1/0", locked_rate, rate_update, violation); else passed++;
        total++; if (half_rate_high !== 16'd20 || half_rate_low !== 16'd20)
            $display("FAIL relock_half: got %0d/%0d want 20/20", half_rate_high, half_rate_low); else passed++;
        send(16'd200);
        total++; if (violation !== 1'b0 || locked_rate !== 16'd40 || state !== 3'd2)
            $display("FAIL gap_ignore: got v=%0d r=%0d s=%0d want 0/40/2", violation, locked_rate, state); else passed++;
        send(16'd42);
        total++; if (violation !== 1'b0 || locked_rate !== 16'd40)
            $display("FAIL tol_edge: got v=%0d r=%0d want 0/40", violation, locked_rate); else passed++;
        send(16'd10);
        total++; if (violation !== 1'b1 || locked !== 1'b1)
            $display("FAIL below_min: got v=%0d l=%0d want 1/1", violation, locked); else passed++;
    endtask

    task automatic test_pause_timeout;
        cfg_pause_timeout = 20'd50;
        restart(3'd1, 2'd0);
        send(16'd100); send(16'd100); send(16'd100);
        tick(49);
        total++; if (state !== 3'd2) $display("FAIL pause_early: got %0d want 2", state); else passed++;
        tick(1);
        total++; if (state !== 3'd3 || paused !== 1'b1 || locked !== 1'b1)
            $display("FAIL paused: got s=%0d p=%0d l=%0d want 3/1/1", state, paused, locked); else passed++;
        send(16'd101);
        total++; if (state !== 3'd2 || paused !== 1'b0)
            $display("FAIL unpause: got s=%0d p=%0d want 2/0", state, paused); else passed++;
        cfg_pause_timeout = 20'd1000;
    endtask

    task automatic test_reset_mid_lock;
        restart(3'd0, 2'd0);
        send(16'd100); send(16'd100);
        sample_valid = 1'b1;
        sample_rate  = 16'd100;
        @(negedge clk);
        sample_valid = 1'b0;
        total++; if (rate_update !== 1'b1) $display("FAIL pre_rst_update: got %0d want 1", rate_update); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (state !== 3'd0 || {locked, paused, rate_update, violation} !== 4'b0000)
            $display("FAIL async_rst_flags: got s=%0d f=%b want 0/0000", state, {locked, paused, rate_update, violation}); else passed++;
        total++; if ({locked_rate, half_rate_high, half_rate_low} !== 48'd0)
            $display("FAIL async_rst_rates: got %0d/%0d/%0d want 0/0/0", locked_rate, half_rate_high, half_rate_low); else passed++;
        @(negedge clk);
        rst = 1'b0;
        restart(3'd0, 2'd0);
        send(16'd100); send(16'd100); send(16'd100);
        total++; if (locked !== 1'b1 || locked_rate !== 16'd100)
            $display("FAIL relock_after_rst: got l=%0d r=%0d want 1/100", locked, locked_rate); else passed++;
    endtask

    task automatic test_back_to_back;
        cfg_lock_target = 4'd0;
        restart(3'd7, 2'd2);
        send(16'd77);
        total++; if (locked !== 1'b1 || locked_rate !== 16'd77)
            $display("FAIL target_zero: got l=%0d r=%0d want 1/77", locked, locked_rate); else passed++;
        total++; if (half_rate_high !== 16'd77 || half_rate_low !== 16'd77 || edge_sel !== 2'b10)
            $display("FAIL mode7_single: got %0d/%0d e=%b want 77/77/10", half_rate_high, half_rate_low, edge_sel); else passed++;
        enable = 1'b0;
        tick(1);
        total++; if (state !== 3'd0 || locked !== 1'b0)
            $display("FAIL disable: got s=%0d l=%0d want 0/0", state, locked); else passed++;
        restart(3'd4, 2'd2);
        total++; if (edge_sel !== 2'b11) $display("FAIL edge_quad: got %b want 11", edge_sel); else passed++;
        send(16'd55);
        total++; if (half_rate_high !== 16'd28 || half_rate_low !== 16'd27)
            $display("FAIL quad_half: got %0d/%0d want 28/27", half_rate_high, half_rate_low); else passed++;
        cfg_lock_target = 4'd3;
    endtask

    initial begin
        test_reset();
        test_single_lock();
        test_half_rates();
        test_violation();
        test_pause_relock();
        test_pause_timeout();
        test_reset_mid_lock();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rate_lock_controller.md
RATE_LOCK_CONTROLLER -- requirements
Module: rate_lock_controller

Interface
REQ-001 Parameter RATE_W, default 16: width of rate samples and rate outputs, in clk cycles.
REQ-002 Parameter LOCK_W, default 4: width of lock/violation counters and their config inputs.
REQ-003 Parameter TIMER_W, default 20: width of the pause timer.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  0 forces IDLE.
REQ-007 cfg_mode  in  3  0 SINGLE_CONT, 1 SINGLE_PAUSE, 2 DIF_CONT, 3 DIF_PAUSE, 4 QUAD_CONT, 5 QUAD_PAUSE; 6/7 decode as SINGLE_CONT.
REQ-008 cfg_polarity  in  2  0 disabled, 1 pos, 2 neg, 3 decodes as disabled.
REQ-009 cfg_odd_high  in  1  odd full-rate remainder goes to the high half when 1, otherwise to the low half.
REQ-010 cfg_tolerance  in  RATE_W  allowed absolute skew.
REQ-011 cfg_min_rate  in  RATE_W  lower bound for a pausable relock.
REQ-012 cfg_lock_target  in  LOCK_W  matching samples required for lock; 0 treated as 1.
REQ-013 cfg_violation_limit  in  LOCK_W  consecutive violations before unlock; 0 treated as 1.
REQ-014 cfg_pause_timeout  in  TIMER_W  idle cycles before PAUSED.
REQ-015 sample_valid / sample_rate  in  1 / RATE_W  measured rate from the half-rate recovery datapath.
REQ-016 edge_sel  out  2  01 rising, 10 falling, 11 any valid edge.
REQ-017 locked, paused, rate_update, violation  out  1 each; rate_update and violation are 1-cycle pulses.
REQ-018 locked_rate, half_rate_high, half_rate_low  out  RATE_W each.
REQ-019 state  out  3  0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 PAUSED.

Function
REQ-020 The controller SHALL latch cfg_mode and cfg_polarity on the IDLE->ACQUIRE transition; the other cfg inputs are used live.
REQ-021 edge_sel SHALL be 11 for QUAD modes or polarity disabled, 01 for pos, 10 for neg; it is combinational from the latched config.
REQ-022 Match SHALL mean |sample_rate - reference| <= cfg_tolerance, computed at RATE_W+1 bits with no wrap.
REQ-023 IDLE->ACQUIRE SHALL occur on the first cycle with enable=1; enable=0 in any state SHALL return to IDLE next cycle and clear all counters.
REQ-024 ACQUIRE: the first sample loads the candidate with match_cnt=1; a matching sample increments match_cnt; a non-matching sample reloads the candidate with match_cnt=1.
REQ-025 When match_cnt reaches cfg_lock_target, the block SHALL enter LOCKED next cycle, load locked_rate=candidate, and pulse rate_update once.
REQ-026 half rates, SINGLE modes: half_rate_high = half_rate_low = locked_rate.
REQ-027 half rates, DIF/QUAD modes: both halves = locked_rate>>1; the odd LSB adds 1 to the half selected by cfg_odd_high.
REQ-028 LOCKED, matching sample: no change; clears viol_cnt.
REQ-029 LOCKED, CONT modes, non-matching sample: pulse violation and increment viol_cnt; reaching cfg_violation_limit SHALL enter ACQUIRE with locked=0.
REQ-030 LOCKED, PAUSE modes, sample < locked_rate>>1 and >= cfg_min_rate: relock; load locked_rate=sample, pulse rate_update, no violation.
REQ-031 LOCKED, PAUSE modes, sample > locked_rate+tol: treated as a pause gap; ignored with no violation.
REQ-032 LOCKED, PAUSE modes, any other non-match: handled as REQ-029.
REQ-033 Pause timer (PAUSE modes only) SHALL clear on every sample_valid and increment otherwise, saturating; reaching cfg_pause_timeout SHALL enter PAUSED.
REQ-034 PAUSED: paused=1 and locked=1 held; a matching sample returns to LOCKED; a non-matching sample is evaluated as in LOCKED.
REQ-035 locked SHALL be 1 in LOCKED and PAUSED only; outputs are registered except edge_sel.

Reset
REQ-036 rst=1 SHALL immediately force the following, regardless of clk: state=IDLE; locked, paused, rate_update, violation = 0; locked_rate, half_rate_high, half_rate_low = 0; all counters and the candidate = 0.
REQ-037 Reset mid-lock SHALL drop any pulse in flight; after release the block restarts from IDLE.

Verification
REQ-038 SINGLE_CONT, tol=2, target=3, samples 100,101,99 -> locked=1 one cycle after the third sample; locked_rate=100; one rate_update pulse.
REQ-039 DIF_CONT, cfg_odd_high=1, locked_rate=101 -> half_rate_high=51, half_rate_low=50; flip cfg_odd_high -> 50/51.
REQ-040 CONT locked at 100, tol=2, violation_limit=2, samples 110,90 -> two violation pulses, then state=ACQUIRE, locked=0.
REQ-041 DIF_PAUSE locked at 100, min_rate=20, sample 40 -> locked_rate=40 with a rate_update pulse; a subsequent sample of 10 -> violation pulse.
REQ-042 SINGLE_PAUSE, pause_timeout=50, no samples -> PAUSED on cycle 50; a matching sample -> LOCKED with paused=0.
REQ-043 Assert rst while LOCKED, then deassert -> all outputs 0 with no clk edge needed, state=IDLE; lock is reacquired normally afterwards.
